// File: rtl/booth_multiplier_core.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock for WIDTH cycles.
// The signed product is registered and held until the consumer takes it.
module booth_multiplier_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH:0]       a_r;
  logic [WIDTH:0]       mx_r;
  logic [WIDTH-1:0]     q_r;
  logic                 qm1_r;
  logic [CW-1:0]        cnt_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       step_a_s;
  logic [WIDTH-1:0]     step_q_s;
  logic                 in_ready_s;
  logic                 out_valid_s;
  logic                 busy_s;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_s = CALC;
        else          state_s = IDLE;
      end
      CALC: begin
        if (cnt_r == CW'(1)) state_s = DONE;
        else                 state_s = CALC;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Handshake outputs decoded purely from the state register
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      CALC:    busy_s     = 1'b1;
      DONE: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: in_ready_s = 1'b0;
    endcase
  end

  // One Booth step: add/subtract by {Q[0], q_m1}, then arithmetic shift of {A, Q}
  always_comb begin
    sum_s = a_r;
    case ({q_r[0], qm1_r})
      2'b01:   sum_s = a_r + mx_r;
      2'b10:   sum_s = a_r - mx_r;
      default: sum_s = a_r;
    endcase
    step_a_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
    step_q_s = {sum_s[0], q_r[WIDTH-1:1]};
  end

  // Datapath registers; product is captured on the final step so it is valid with out_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      mx_r      <= '0;
      q_r       <= '0;
      qm1_r     <= 1'b0;
      cnt_r     <= '0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mx_r  <= {multiplicand[WIDTH-1], multiplicand};
            q_r   <= multiplier;
            a_r   <= '0;
            qm1_r <= 1'b0;
            cnt_r <= CW'(WIDTH);
          end
        end
        CALC: begin
          a_r   <= step_a_s;
          q_r   <= step_q_s;
          qm1_r <= q_r[0];
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            product_r <= {step_a_s[WIDTH-1:0], step_q_s};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign busy      = busy_s;
  assign product   = product_r;

endmodule

// File: tb/tb_booth_multiplier_core.sv
// Scoreboard bench for booth_multiplier_core: directed vectors, backpressure,
// mid-operation reset and a random back-to-back run against a signed reference.
module tb_booth_multiplier_core;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int n_acc    = 0;
  logic prev_ov = 1'b0;
  logic [2*W-1:0] sb_q[$];

  booth_multiplier_core #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] sm;
    logic signed [2*W-1:0] sq;
    sm = {{W{m[W-1]}}, m};
    sq = {{W{q[W-1]}}, q};
    return sm * sq;
  endfunction

  // Monitor: accepts push the model result, handoffs pop and compare
  initial forever begin
    @(negedge clk);
    if (reset) begin
      sb_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc), 64'd16);
      if (out_valid && out_ready) begin
        check("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) check("product_model", 64'(product), 64'(sb_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        check("one_in_flight", 64'(sb_q.size()), 64'd0);
        sb_q.push_back(ref_mul(multiplicand, multiplier));
        acc_cyc = cyc + 1;
        n_acc++;
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [W-1:0] m, input logic [W-1:0] q, input int hold,
                       input logic [2*W-1:0] want);
    int n;
    logic [2*W-1:0] held;
    multiplicand = m;
    multiplier   = q;
    in_valid     = 1'b1;
    out_ready    = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("accept_wait", 64'(n < 50), 64'd1);
    @(posedge clk); #1;
    in_valid     = 1'b0;
    multiplicand = ~m;
    multiplier   = ~q;
    check("in_ready_fall", 64'(in_ready), 64'd0);
    check("busy_calc", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_wait", 64'(out_valid), 64'd1);
    check("product_vec", 64'(product), 64'(want));
    held = product;
    for (int i = 0; i < hold; i++) begin
      in_valid     = i[0];
      multiplicand = 16'h7777;
      multiplier   = 16'h1111;
      @(posedge clk); #1;
      check("bp_product", 64'(product), 64'(held));
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("in_ready_back", 64'(in_ready), 64'd1);
    check("out_valid_drop", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int n_ov;
    int base;
    logic [31:0] r;
    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_product", 64'(product), 64'd0);

    // reset and in_valid together: nothing is accepted
    in_valid     = 1'b1;
    multiplicand = 16'h0005;
    multiplier   = 16'h0005;
    @(posedge clk); #1;
    check("rst_vs_valid_ready", 64'(in_ready), 64'd1);
    check("rst_vs_valid_busy", 64'(busy), 64'd0);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(posedge clk); #1;

    do_op(16'h0003, 16'h0005, 0, 32'h0000_000F);
    do_op(16'hFFF9, 16'h0006, 0, 32'hFFFF_FFD6);
    do_op(16'h0006, 16'hFFF9, 0, 32'hFFFF_FFD6);
    do_op(16'hFFF9, 16'hFFFA, 0, 32'h0000_002A);
    do_op(16'h8000, 16'h8000, 0, 32'h4000_0000);
    do_op(16'h8000, 16'h7FFF, 0, 32'hC000_8000);
    do_op(16'h0000, 16'h1234, 0, 32'h0000_0000);
    do_op(16'h0123, 16'h0045, 10, 32'h0000_4E6F);

    // reset in the middle of a 9 x 9 operation
    multiplicand = 16'h0009;
    multiplier   = 16'h0009;
    in_valid     = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_product", 64'(product), 64'd0);
    reset = 1'b0;
    n_ov  = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) n_ov++;
    end
    check("rst_mid_no_out", 64'(n_ov), 64'd0);
    do_op(16'h0002, 16'h0002, 0, 32'h0000_0004);

    // random back-to-back with random backpressure
    base     = n_acc;
    n        = 0;
    in_valid = 1'b1;
    while (n_acc < base + 1000 && n < 60000) begin
      r            = $urandom;
      multiplicand = r[15:0];
      r            = $urandom;
      multiplier   = r[15:0];
      out_ready    = r[16];
      @(posedge clk); #1;
      n++;
    end
    check("random_accepts", 64'(n_acc - base), 64'd1000);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb_q.size() > 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
